// File: rtl/mole_controller_pkg.sv
// Shared game constants, state encoding and small helpers for the mole controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mole_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GAP   = 2'd1,
        ST_UP    = 2'd2,
        ST_FLASH = 2'd3
    } mole_state_t;

    localparam int NUM_HOLES = 8;
    localparam int POS_W     = 3;
    localparam int MS_W      = 10;

    localparam logic [MS_W-1:0] GAP_MS   = 10'd250;
    localparam logic [MS_W-1:0] FLASH_MS = 10'd100;

    // Mole up-time in ms, indexed by latched difficulty (0 = easy).
    localparam logic [3:0][MS_W-1:0] UP_MS_TBL = {10'd300, 10'd500, 10'd750, 10'd1000};

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // One-hot LED pattern for a hole index.
    function automatic logic [NUM_HOLES-1:0] hole_onehot(input logic [POS_W-1:0] pos);
        hole_onehot      = '0;
        hole_onehot[pos] = 1'b1;
    endfunction

    // Next mole position: random pick, bumped by one (mod 8) if it repeats the last hole.
    function automatic logic [POS_W-1:0] pick_pos(input logic [POS_W-1:0] rnd,
                                                  input logic [POS_W-1:0] prev);
        pick_pos = (rnd == prev) ? rnd + 3'd1 : rnd;
    endfunction

endpackage

// File: rtl/mole_controller_if.sv
// Groups the game-side controls and the mole controller's display/score outputs.
// Latency: n/a (wiring only).
// Backpressure: none; all outputs are one-cycle pulses or levels.
interface mole_controller_if;
    import mole_controller_pkg::*;

    logic                 enable_mole_ctrl;
    logic [1:0]           difficulty_level;
    logic [NUM_HOLES-1:0] btn_hit;

    logic [NUM_HOLES-1:0] mole_leds;
    logic [POS_W-1:0]     mole_pos;
    logic                 mole_active;
    logic                 hit_pulse;
    logic                 miss_pulse;
    logic                 wrong_pulse;

    // Game logic / button side.
    modport master (
        output enable_mole_ctrl, difficulty_level, btn_hit,
        input  mole_leds, mole_pos, mole_active, hit_pulse, miss_pulse, wrong_pulse
    );

    // Mole controller side.
    modport slave (
        input  enable_mole_ctrl, difficulty_level, btn_hit,
        output mole_leds, mole_pos, mole_active, hit_pulse, miss_pulse, wrong_pulse
    );
endinterface

// File: rtl/mole_controller_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, used to pick mole holes.
// Latency: new value every clock.
// Backpressure: none; advances unconditionally and never reaches zero.
module lfsr8
    import mole_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] value
);

    logic fb;

    assign fb = value[7] ^ value[5] ^ value[4] ^ value[3];

    // Shift left, feeding the tap parity into bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= LFSR_SEED;
        end else begin
            value <= {value[6:0], fb};
        end
    end

endmodule

// File: rtl/mole_controller.sv
// Whack-a-mole sequencer: gap, mole up, flash after a hit; emits hit/miss/wrong pulses.
// Latency: all outputs registered, one cycle after the triggering button or timer event.
// Backpressure: none; buttons outside the UP state are dropped, enable low forces IDLE.
module mole_controller
    import mole_controller_pkg::*;
#(
    parameter int CLKS_PER_MS = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    mole_controller_if.slave  bus
);

    localparam int              PRE_W    = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_MS - 1);

    mole_state_t          state, nxt_state;
    logic [PRE_W-1:0]     presc, nxt_presc;
    logic [MS_W-1:0]      ms_cnt, nxt_ms_cnt;
    logic [1:0]           up_sel, nxt_up_sel;
    logic [POS_W-1:0]     pos_q, nxt_pos;
    logic [NUM_HOLES-1:0] leds_q, nxt_leds;
    logic                 active_q, nxt_active;
    logic                 hit_q, nxt_hit;
    logic                 miss_q, nxt_miss;
    logic                 wrong_q, nxt_wrong;

    logic [7:0]           lfsr_val;
    logic                 lfsr_unused;
    logic                 ms_tick;
    logic                 phase_done;
    logic [MS_W-1:0]      phase_ms;

    lfsr8 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .value (lfsr_val)
    );

    // Only the low three LFSR bits select a hole; the rest just keep the sequence long.
    assign lfsr_unused = ^lfsr_val[7:3];

    // Length in ms of the state currently being timed.
    always_comb begin
        phase_ms = GAP_MS;
        case (state)
            ST_UP:    phase_ms = UP_MS_TBL[up_sel];
            ST_FLASH: phase_ms = FLASH_MS;
            default:  phase_ms = GAP_MS;
        endcase
    end

    assign ms_tick    = (presc == PRE_LAST);
    assign phase_done = ms_tick && (ms_cnt == phase_ms - MS_W'(1));

    // Next state and next registered outputs; enable low overrides everything.
    always_comb begin
        nxt_state  = state;
        nxt_up_sel = up_sel;
        nxt_pos    = pos_q;
        nxt_leds   = '0;
        nxt_active = 1'b0;
        nxt_hit    = 1'b0;
        nxt_miss   = 1'b0;
        nxt_wrong  = 1'b0;

        if (!bus.enable_mole_ctrl) begin
            nxt_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    nxt_state = ST_GAP;
                end
                ST_GAP: begin
                    if (phase_done) begin
                        nxt_state  = ST_UP;
                        nxt_pos    = pick_pos(lfsr_val[2:0], pos_q);
                        nxt_up_sel = bus.difficulty_level;
                    end
                end
                ST_UP: begin
                    // A correct hit beats both a wrong press and a timeout in the same cycle.
                    if (bus.btn_hit[pos_q]) begin
                        nxt_state = ST_FLASH;
                        nxt_hit   = 1'b1;
                    end else begin
                        nxt_wrong = |bus.btn_hit;
                        if (phase_done) begin
                            nxt_state = ST_GAP;
                            nxt_miss  = 1'b1;
                        end
                    end
                end
                ST_FLASH: begin
                    if (phase_done) begin
                        nxt_state = ST_GAP;
                    end
                end
                default: begin
                    nxt_state = ST_IDLE;
                end
            endcase
        end

        if (nxt_state == ST_UP) begin
            nxt_leds   = hole_onehot(nxt_pos);
            nxt_active = 1'b1;
        end
    end

    // Millisecond timebase: restarts on every state entry, idles at zero in IDLE.
    always_comb begin
        nxt_presc  = '0;
        nxt_ms_cnt = '0;
        if ((nxt_state == state) && (state != ST_IDLE)) begin
            nxt_presc  = ms_tick ? '0 : presc + PRE_W'(1);
            nxt_ms_cnt = ms_tick ? ms_cnt + MS_W'(1) : ms_cnt;
        end
    end

    // State, timebase and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            presc    <= '0;
            ms_cnt   <= '0;
            up_sel   <= '0;
            pos_q    <= '0;
            leds_q   <= '0;
            active_q <= 1'b0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            wrong_q  <= 1'b0;
        end else begin
            state    <= nxt_state;
            presc    <= nxt_presc;
            ms_cnt   <= nxt_ms_cnt;
            up_sel   <= nxt_up_sel;
            pos_q    <= nxt_pos;
            leds_q   <= nxt_leds;
            active_q <= nxt_active;
            hit_q    <= nxt_hit;
            miss_q   <= nxt_miss;
            wrong_q  <= nxt_wrong;
        end
    end

    assign bus.mole_leds   = leds_q;
    assign bus.mole_pos    = pos_q;
    assign bus.mole_active = active_q;
    assign bus.hit_pulse   = hit_q;
    assign bus.miss_pulse  = miss_q;
    assign bus.wrong_pulse = wrong_q;

endmodule

// File: tb/tb_mole_controller.sv
// Randomised bench for mole_controller with a phase/countdown reference model and output scoreboard.
// Latency: model predicts the registered outputs for the cycle after each sampled edge.
// Backpressure: n/a.
module tb_mole_controller;

    localparam int CPM = 4;
    localparam int GAP_CYC   = 250 * CPM;
    localparam int FLASH_CYC = 100 * CPM;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mole_controller_if bus();

    mole_controller #(.CLKS_PER_MS(CPM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] leds;
        logic [2:0] pos;
        logic       active;
        logic       hit;
        logic       miss;
        logic       wrong;
    } obs_t;

    typedef enum int {M_IDLE, M_GAP, M_UP, M_FLASH} mph_t;

    int up_ms [4] = '{1000, 750, 500, 300};

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    mph_t       m_ph    = M_IDLE;
    int         m_left  = 0;
    logic [2:0] m_pos   = 3'd0;
    logic [7:0] m_lfsr  = 8'hA5;
    logic [7:0] m_seen  = 8'h00;
    int         m_moles = 0;

    // DUT-side observation for the random run
    logic       track_en   = 1'b0;
    logic       prev_act   = 1'b0;
    logic       have_last  = 1'b0;
    logic [2:0] last_pos   = 3'd0;
    int         rep_cnt    = 0;
    logic [7:0] dut_seen   = 8'h00;
    int         dut_moles  = 0;

    // Reference model: advance one cycle of game rules and queue the expected outputs.
    always @(posedge clk) begin : model
        obs_t       e;
        logic [2:0] r;
        if (rst_n) begin
            e = '0;
            if (!bus.enable_mole_ctrl) begin
                m_ph = M_IDLE;
            end else begin
                case (m_ph)
                    M_IDLE: begin
                        m_ph   = M_GAP;
                        m_left = GAP_CYC;
                    end
                    M_GAP: begin
                        m_left = m_left - 1;
                        if (m_left == 0) begin
                            r      = m_lfsr[2:0];
                            m_pos  = (r == m_pos) ? r + 3'd1 : r;
                            m_ph   = M_UP;
                            m_left = up_ms[bus.difficulty_level] * CPM;
                            if (track_en) begin
                                m_seen[m_pos] = 1'b1;
                                m_moles       = m_moles + 1;
                            end
                        end
                    end
                    M_UP: begin
                        if (bus.btn_hit[m_pos]) begin
                            e.hit  = 1'b1;
                            m_ph   = M_FLASH;
                            m_left = FLASH_CYC;
                        end else begin
                            e.wrong = (bus.btn_hit != 8'h00);
                            m_left  = m_left - 1;
                            if (m_left == 0) begin
                                e.miss = 1'b1;
                                m_ph   = M_GAP;
                                m_left = GAP_CYC;
                            end
                        end
                    end
                    default: begin
                        m_left = m_left - 1;
                        if (m_left == 0) begin
                            m_ph   = M_GAP;
                            m_left = GAP_CYC;
                        end
                    end
                endcase
            end
            m_lfsr   = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
            e.leds   = (m_ph == M_UP) ? (8'd1 << m_pos) : 8'd0;
            e.pos    = m_pos;
            e.active = (m_ph == M_UP);
            exp_q.push_back(e);
        end
    end

    // Monitor: compare every presented output cycle against the queued expectation.
    always @(negedge clk) begin : monitor
        obs_t a;
        obs_t e;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.mole_leds, bus.mole_pos, bus.mole_active,
                 bus.hit_pulse, bus.miss_pulse, bus.wrong_pulse};
            n_cmp = n_cmp + 1;
            if (a !== e) begin
                n_bad = n_bad + 1;
                $display("FAIL outputs t=%0t got leds=%h pos=%0d act=%b hit=%b miss=%b wrong=%b want leds=%h pos=%0d act=%b hit=%b miss=%b wrong=%b",
                         $time, a.leds, a.pos, a.active, a.hit, a.miss, a.wrong,
                         e.leds, e.pos, e.active, e.hit, e.miss, e.wrong);
            end
            if (track_en && bus.mole_active && !prev_act) begin
                if (have_last && bus.mole_pos == last_pos) rep_cnt = rep_cnt + 1;
                last_pos  = bus.mole_pos;
                have_last = 1'b1;
                dut_seen[bus.mole_pos] = 1'b1;
                dut_moles = dut_moles + 1;
            end
            prev_act = bus.mole_active;
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        cmp({tag, "_leds"},  32'(bus.mole_leds),   32'd0);
        cmp({tag, "_pos"},   32'(bus.mole_pos),    32'd0);
        cmp({tag, "_act"},   32'(bus.mole_active), 32'd0);
        cmp({tag, "_hit"},   32'(bus.hit_pulse),   32'd0);
        cmp({tag, "_miss"},  32'(bus.miss_pulse),  32'd0);
        cmp({tag, "_wrong"}, 32'(bus.wrong_pulse), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ph(input mph_t ph, input int budget, input string what);
        int n;
        n = 0;
        while (m_ph != ph && n < budget) begin
            tick();
            n = n + 1;
        end
        if (m_ph != ph) begin
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL timeout_%s: state %0d after %0d cycles, wanted %0d", what, m_ph, n, ph);
        end
    endtask

    task automatic press(input logic [7:0] v);
        bus.btn_hit = v;
        tick();
        bus.btn_hit = 8'h00;
    endtask

    function automatic logic [7:0] wrong_mask(input logic [2:0] pos);
        logic [7:0] v;
        v = 8'($urandom_range(1, 255)) & ~(8'd1 << pos);
        if (v == 8'h00) v = 8'd1 << (pos + 3'd1);
        return v;
    endfunction

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        bus.enable_mole_ctrl = 1'b0;
        bus.difficulty_level = 2'd0;
        bus.btn_hit          = 8'h00;
        rst_n = 1'b0;
        #3;
        check_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Easy mole left to time out: 1000-cycle gap, 4000-cycle mole, miss.
        bus.enable_mole_ctrl = 1'b1;
        wait_ph(M_UP, GAP_CYC + 5, "first_up");
        bus.difficulty_level = 2'd3;
        wait_ph(M_GAP, 4000 + 5, "easy_timeout");

        // Hardest difficulty, correct hit at UP cycle 10, then flash and gap.
        wait_ph(M_UP, GAP_CYC + 5, "hard_up");
        repeat (10) tick();
        press(8'd1 << m_pos);
        wait_ph(M_GAP, FLASH_CYC + 5, "flash_end");

        // Wrong press keeps the mole up; mixed press counts as a hit; enable drop in FLASH.
        wait_ph(M_UP, GAP_CYC + 5, "wrong_up");
        repeat (3) tick();
        press(wrong_mask(m_pos));
        repeat (2) tick();
        press(wrong_mask(m_pos) | (8'd1 << m_pos));
        repeat (20) tick();
        bus.enable_mole_ctrl = 1'b0;
        tick();
        bus.enable_mole_ctrl = 1'b1;
        wait_ph(M_GAP, FLASH_CYC + 5, "regap");

        // Hit in the final UP cycle wins over the timeout.
        wait_ph(M_UP, GAP_CYC + 5, "last_up");
        n = 0;
        while (m_left != 1 && n < 1300) begin
            tick();
            n = n + 1;
        end
        cmp("last_cycle_reached", 32'(m_left), 32'd1);
        press(8'd1 << m_pos);

        // Enable dropped together with a correct hit: no pulse, IDLE.
        wait_ph(M_UP, FLASH_CYC + GAP_CYC + 5, "drop_up");
        repeat (5) tick();
        bus.enable_mole_ctrl = 1'b0;
        press(8'd1 << m_pos);
        tick();
        bus.enable_mole_ctrl = 1'b1;

        // Randomised run: random buttons and difficulty changes every cycle.
        track_en = 1'b1;
        for (int k = 0; k < 30; k++) begin
            wait_ph(M_UP, FLASH_CYC + GAP_CYC + 5, "rand_up");
            n = 0;
            while (m_ph == M_UP && n < 4100) begin
                bus.difficulty_level = 2'($urandom_range(0, 3));
                bus.btn_hit = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
                tick();
                n = n + 1;
            end
            bus.btn_hit = 8'h00;
        end
        bus.difficulty_level = 2'd2;
        wait_ph(M_GAP, FLASH_CYC + 5, "rand_tail");
        tick();
        track_en = 1'b0;
        cmp("rand_repeats", 32'(rep_cnt), 32'd0);
        cmp("rand_holes_seen", 32'(dut_seen), 32'(m_seen));
        cmp("rand_mole_count", 32'(dut_moles), 32'(m_moles));

        // Asynchronous reset in the middle of UP.
        wait_ph(M_UP, GAP_CYC + 5, "reset_up");
        repeat (7) tick();
        #2 rst_n = 1'b0;
        #1;
        check_zero("midup_reset");
        exp_q.delete();
        m_ph   = M_IDLE;
        m_left = 0;
        m_pos  = 3'd0;
        m_lfsr = 8'hA5;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ph(M_UP, GAP_CYC + 5, "post_reset_up");
        repeat (4) tick();
        bus.enable_mole_ctrl = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mole_controller.md
MOLE_CONTROLLER -- requirements
Module: mole_controller

Interface
REQ-001 Parameter: CLKS_PER_MS, default 100000, clock cycles per millisecond (100 MHz clock).
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- enable_mole_ctrl  in  1  level; high while the game is in PLAYING.
- difficulty_level  in  2  0 = easy ... 3 = hardest.
- btn_hit  in  8  one-cycle hit pulses, one per hole, already debounced.
- mole_leds  out  8  one-hot lit hole; all zero when no mole is up.
- mole_pos  out  3  index of current/last mole.
- mole_active  out  1  high while in UP.
- hit_pulse  out  1  one-cycle pulse, correct hole hit; drives score increment.
- miss_pulse  out  1  one-cycle pulse, mole timed out unhit.
- wrong_pulse  out  1  one-cycle pulse, wrong hole pressed while a mole is up.

Function
REQ-003 States: IDLE, GAP, UP, FLASH; all outputs registered.
REQ-004 Millisecond timebase:
- prescaler counts 0..CLKS_PER_MS-1 and emits ms_tick on wrap;
- prescaler and the 10-bit ms counter clear on every state entry;
- state duration D ms = exactly D*CLKS_PER_MS cycles.
REQ-005 IDLE: when enable_mole_ctrl=1, go to GAP next cycle; otherwise stay.
REQ-006 GAP: lasts 250 ms; mole_leds=0; then go to UP.
REQ-007 On the GAP->UP transition:
- mole_pos <= LFSR[2:0];
- if that equals the previous mole_pos, mole_pos <= (LFSR[2:0]+1) mod 8;
- difficulty_level latched as up_sel.
REQ-008 UP duration by up_sel: 0=1000 ms, 1=750 ms, 2=500 ms, 3=300 ms. Difficulty changes mid-UP have no effect.
REQ-009 UP outputs: mole_leds = 1<<mole_pos, mole_active=1.
REQ-010 In UP, when btn_hit[mole_pos]=1 in cycle N:
- hit_pulse=1 in cycle N+1, for one cycle only;
- state=FLASH in cycle N+1;
- mole_leds=0 from cycle N+1.
REQ-011 In UP, btn_hit nonzero with btn_hit[mole_pos]=0 -> wrong_pulse=1 for one cycle; no state change; at most one wrong_pulse per cycle regardless of bit count.
REQ-012 Correct and wrong bits in the same cycle -> hit_pulse only, no wrong_pulse.
REQ-013 Timeout (last UP cycle, no hit) -> miss_pulse=1 for one cycle coincident with entry to GAP. A hit in the final UP cycle wins: hit_pulse, no miss_pulse.
REQ-014 FLASH: lasts 100 ms; mole_leds=0; btn_hit ignored; then go to GAP.
REQ-015 btn_hit ignored in IDLE, GAP, FLASH: no pulses.
REQ-016 enable_mole_ctrl=0 in any state -> IDLE next cycle:
- mole_leds=0, mole_active=0, no pulses that cycle;
- overrides a simultaneous hit or timeout.
REQ-017 LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, advances every clock regardless of state; never reaches zero.

Reset
REQ-018 rst_n=0 asynchronously forces:
- state=IDLE;
- mole_leds=0, mole_pos=0, mole_active=0;
- hit_pulse=0, miss_pulse=0, wrong_pulse=0;
- prescaler=0, ms counter=0, up_sel=0, LFSR=8'hA5.
REQ-019 Reset asserted mid-UP or mid-FLASH drops the outputs in REQ-018 immediately, with no pulses emitted. First GAP after release requires enable_mole_ctrl=1.

Structure
REQ-020 Shared game package holds: state encoding, NUM_HOLES=8, GAP_MS=250, FLASH_MS=100, the up-time table indexed by difficulty, and LFSR_SEED=8'hA5.
REQ-021 One sub-module, lfsr8 (clk, rst_n, value[7:0]), instantiated once.
REQ-022 Implementation budget: 120-400 lines of RTL.

Verification (CLKS_PER_MS=4)
REQ-023 Enable=1, difficulty=0:
- GAP lasts 1000 cycles, then mole_leds one-hot for 4000 cycles;
- then miss_pulse, then the next GAP.
REQ-024 Difficulty=3, UP at mole_pos=5, btn_hit=8'h20 at UP cycle 10:
- hit_pulse next cycle;
- 400-cycle FLASH with mole_leds=0;
- then 1000-cycle GAP.
REQ-025 mole_pos=2:
- btn_hit=8'h01 -> wrong_pulse only, mole stays up;
- btn_hit=8'h05 -> hit_pulse only.
REQ-026 Hit in the last UP cycle -> hit_pulse, no miss_pulse. Enable dropped with a simultaneous hit -> no pulses, IDLE next cycle.
REQ-027 Run 200 consecutive moles -> no two consecutive equal mole_pos values, all 8 holes appear.
REQ-028 Assert rst_n mid-UP -> outputs zero immediately; after release, LFSR first value matches the 8'hA5 sequence.
